// File: rtl/eeprom_word_sequencer_pkg.sv
// Shared definitions for the EEPROM word sequencer: controller op_mode and
// clk_rate codes, o_ctrl / i_status bit positions, and the sequencer state enum.
package eeprom_word_sequencer_pkg;

    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;

    localparam logic [2:0] RATE_390K  = 3'd7;
    localparam logic [2:0] RATE_781K  = 3'd6;
    localparam logic [2:0] RATE_1M56  = 3'd5;
    localparam logic [2:0] RATE_3M125 = 3'd4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_OP_LSB     = 1;
    localparam int CTRL_RATE_LSB   = 4;
    localparam int STAT_FINISH_BIT = 1;
    localparam int STAT_SM_EN_BIT  = 10;

    localparam int RETRY_GAP_CYCLES = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_ACCEPT,
        S_WAIT_END,
        S_WR_CYCLE,
        S_RETRY_GAP,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/eeprom_word_sequencer_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level, with rise/fall detection
// on the synchronized value.
//   i_clk  : sampling clock
//   i_rst  : asynchronous active-high reset
//   i_d    : asynchronous input level
//   o_q    : synchronized level
//   o_rise : one-cycle pulse when o_q goes 0 -> 1
//   o_fall : one-cycle pulse when o_q goes 1 -> 0
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    logic [2:0] shift_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q <= '0;
        end else begin
            shift_q <= {shift_q[1:0], i_d};
        end
    end

    assign o_q    = shift_q[1];
    assign o_rise = shift_q[1] & ~shift_q[2];
    assign o_fall = ~shift_q[1] & shift_q[2];

endmodule

// File: rtl/eeprom_word_sequencer.sv
// Sequences one 32-bit EEPROM word read or write through an I2C controller
// that is armed by o_ctrl[0] and reports progress through i_status.
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_req/i_rw/i_addr/i_wdata : request (start pulse, 0 = write / 1 = read)
//   o_busy/o_done/o_err/o_rdata : response (o_err valid with o_done)
//   o_dev_addr/o_reg_addr/o_w_data/o_ctrl : controller configuration
//   i_status, i_rd_data0..3 : controller status ([1] finish, [10] sm_enable)
//                             and received bytes, first to last
//
// state         | meaning
// S_IDLE        | waiting for i_req
// S_ARM         | raise controller enable, clear finish flag and timeout
// S_WAIT_ACCEPT | wait for controller to report sm_enable
// S_WAIT_END    | enable dropped; wait for sm_enable to fall
// S_WR_CYCLE    | EEPROM internal write-cycle wait
// S_RETRY_GAP   | pause after a NACK before re-arming
// S_DONE        | one-cycle completion pulse
module eeprom_word_sequencer
    import eeprom_word_sequencer_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter logic [2:0] CLK_RATE       = 3'd7,
    parameter int         TWR_CYCLES     = 500000,
    parameter int         TIMEOUT_CYCLES = 2000000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [6:0]  o_dev_addr,
    output logic [15:0] o_reg_addr,
    output logic [31:0] o_w_data,
    output logic [31:0] o_ctrl,
    input  logic [31:0] i_status,
    input  logic [7:0]  i_rd_data0,
    input  logic [7:0]  i_rd_data1,
    input  logic [7:0]  i_rd_data2,
    input  logic [7:0]  i_rd_data3
);

    localparam logic [31:0] TWR_LOAD    = 32'(TWR_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD    = 32'(RETRY_GAP_CYCLES - 1);
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);

    seq_state_e  state_q, state_d;
    logic        rw_q, err_q, ctrl_en_q, fin_flag_q;
    logic [2:0]  op_q, rate_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q, rdata_q, tmo_cnt_q, wait_cnt_q;
    logic [7:0]  retry_q;

    logic        fin_level, fin_rise, fin_fall;
    logic        sm_en, sm_rise, sm_fall;
    logic        take_req, ctrl_off, load_wait, inc_retry, load_rdata;
    logic        finish_op, finish_err;
    logic [31:0] load_val;
    logic        tmo_hit, finish_seen, in_wait;
    logic        unused_sig;

    sync_edge_det u_sync_finish (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_status[STAT_FINISH_BIT]),
        .o_q    (fin_level),
        .o_rise (fin_rise),
        .o_fall (fin_fall)
    );

    sync_edge_det u_sync_sm_en (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_status[STAT_SM_EN_BIT]),
        .o_q    (sm_en),
        .o_rise (sm_rise),
        .o_fall (sm_fall)
    );

    assign unused_sig = ^{i_status[31:11], i_status[9:2], i_status[0],
                          fin_level, fin_fall, sm_rise};

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    assign in_wait = (state_q == S_WAIT_ACCEPT) || (state_q == S_WAIT_END);
    // A finish rise landing in the same cycle as the sm_enable fall still counts.
    assign finish_seen = fin_flag_q | fin_rise;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        take_req   = 1'b0;
        ctrl_off   = 1'b0;
        load_wait  = 1'b0;
        load_val   = '0;
        inc_retry  = 1'b0;
        load_rdata = 1'b0;
        finish_op  = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    take_req = 1'b1;
                    if (i_addr[1:0] != 2'b00) begin
                        finish_op  = 1'b1;
                        finish_err = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: state_d = S_WAIT_ACCEPT;
            S_WAIT_ACCEPT: begin
                if (tmo_hit) begin
                    ctrl_off   = 1'b1;
                    finish_op  = 1'b1;
                    finish_err = 1'b1;
                    state_d    = S_DONE;
                end else if (sm_en) begin
                    // Drop enable once accepted so the controller cannot re-arm.
                    ctrl_off = 1'b1;
                    state_d  = S_WAIT_END;
                end
            end
            S_WAIT_END: begin
                if (sm_fall) begin
                    if (finish_seen) begin
                        if (rw_q) begin
                            load_rdata = 1'b1;
                            finish_op  = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            load_wait = 1'b1;
                            load_val  = TWR_LOAD;
                            state_d   = S_WR_CYCLE;
                        end
                    end else if (retry_q < RETRY_LIMIT) begin
                        load_wait = 1'b1;
                        load_val  = GAP_LOAD;
                        state_d   = S_RETRY_GAP;
                    end else begin
                        finish_op  = 1'b1;
                        finish_err = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (tmo_hit) begin
                    ctrl_off   = 1'b1;
                    finish_op  = 1'b1;
                    finish_err = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_WR_CYCLE: begin
                if (wait_cnt_q == '0) begin
                    finish_op = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_RETRY_GAP: begin
                if (wait_cnt_q == '0) begin
                    inc_retry = 1'b1;
                    state_d   = S_ARM;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            rate_q     <= '0;
            retry_q    <= '0;
            err_q      <= 1'b0;
            ctrl_en_q  <= 1'b0;
            fin_flag_q <= 1'b0;
            tmo_cnt_q  <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (take_req) begin
                rw_q    <= i_rw;
                addr_q  <= i_addr;
                wdata_q <= i_wdata;
                op_q    <= i_rw ? OP_READ : OP_WRITE;
                rate_q  <= CLK_RATE;
                retry_q <= '0;
                err_q   <= 1'b0;
            end
            if (state_q == S_ARM) begin
                ctrl_en_q  <= 1'b1;
                fin_flag_q <= 1'b0;
                tmo_cnt_q  <= '0;
            end else begin
                if (fin_rise) begin
                    fin_flag_q <= 1'b1;
                end
                if (in_wait) begin
                    tmo_cnt_q <= tmo_cnt_q + 32'd1;
                end
            end
            if (ctrl_off) begin
                ctrl_en_q <= 1'b0;
            end
            if (load_wait) begin
                wait_cnt_q <= load_val;
            end else if (wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 32'd1;
            end
            if (inc_retry) begin
                retry_q <= retry_q + 8'd1;
            end
            if (load_rdata) begin
                rdata_q <= {i_rd_data0, i_rd_data1, i_rd_data2, i_rd_data3};
            end
            if (finish_op) begin
                err_q <= finish_err;
            end
        end
    end

    always_comb begin
        o_ctrl                          = '0;
        o_ctrl[CTRL_EN_BIT]             = ctrl_en_q;
        o_ctrl[CTRL_OP_LSB +: 3]        = op_q;
        o_ctrl[CTRL_RATE_LSB +: 3]      = rate_q;
    end

    assign o_busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done     = (state_q == S_DONE);
    assign o_err      = err_q;
    assign o_rdata    = rdata_q;
    assign o_dev_addr = DEV_ADDR;
    assign o_reg_addr = addr_q;
    assign o_w_data   = wdata_q;

endmodule
